text_pixel_pipe: RTL and testbench
==================================

// Module: text_pixel_pipe
// PURPOSE
//  Video-side render pipeline for the 80x30 text mode (640x480, 8x16 cells, 8x8 font double-scanned).
//  Consumes raw timing (counters, DE, syncs) and drives the char/attr RAM video read port and the font ROM.
//  Produces one RGB888 pixel per clock with syncs/DE delayed to match, and overlays a blinking cursor.
//  Sits between the video timing generator and the HDMI/TMDS encoder.
// PARAMETERS
//  COLS        80   text columns; cell addr = row*COLS + col
//  ROWS        30   text rows
//  BLINK_BIT   4    frame-counter bit driving cursor/char blink (period 2^(BLINK_BIT+1) frames)
// PORTS
//  clk          in   1   pixel clock; RAM video port and font ROM run on it
//  rst_n        in   1   asynchronous active-low reset
//  hcount       in   10  pixel x of current timing position
//  vcount       in   10  line y of current timing position
//  de_in        in   1   active video at (hcount,vcount)
//  hsync_in     in   1   horizontal sync, passed through
//  vsync_in     in   1   vertical sync (active-high), passed through; rising edge = new frame
//  cursor_en    in   1   show cursor
//  cursor_col   in   7   cursor column 0..COLS-1
//  cursor_row   in   5   cursor row 0..ROWS-1
//  v_en         out  1   char RAM read enable
//  v_addr       out  12  char RAM address 0..2399
//  v_char       in   8   char code, valid 1 clk after v_en
//  v_attr       in   8   attribute, valid 1 clk after v_en
//  font_char    out  8   font ROM char code
//  font_row     out  3   font ROM row
//  font_pixels  in   8   font row bits, bit7 = leftmost, valid 1 clk after font_char
//  rgb          out  24  {R,G,B} pixel
//  de_out       out  1   DE aligned to rgb
//  hsync_out    out  1   hsync aligned to rgb
//  vsync_out    out  1   vsync aligned to rgb
// BEHAVIOUR
//  - Reset: v_en=0, v_addr=0, font_char=0, font_row=0, rgb=0, de_out=0, hsync_out=0, vsync_out=0, frame ctr=0, pipes cleared.
//  - Stage 0 (combinational on inputs): col=hcount[9:3], row=vcount[9:4]; v_addr=(row<<6)+(row<<4)+col; v_en=de_in.
//    v_en forced 0 when col>=COLS or row>=ROWS even with de_in high; that cell renders as bg-black (rgb=0).
//  - Stage 1: font_char=v_char (combinational from RAM output); font_row=vcount_d1[3:1] (double scan).
//  - Stage 2: pixel bit = font_pixels[7 - hcount_d2[2:0]]; attr_d2 = v_attr delayed 1.
//  - Stage 3: rgb registered. Total latency input->rgb = 3 clk; de/hsync/vsync delayed exactly 3 clk.
//  - Attribute: fg=attr[3:0] (16-colour palette), bg={1'b0,attr[6:4]}, attr[7]=blink: when set and blink phase low, fg shown as bg.
//  - Cursor: cell (cursor_row,cursor_col) with cursor_en=1 and blink phase high -> cell scanlines 14,15 (vcount[3:0]>=14) all pixels fg.
//  - Blink phase = frame_ctr[BLINK_BIT]; frame_ctr is 8-bit, +1 on vsync_in rising edge (edge-detect reg), wraps 255->0.
//  - de delayed low -> rgb=0 regardless of pipe contents.
//  - Cursor inputs sampled at stage 0 with the pixel; changes mid-frame take effect on next pixel (no tearing protection).
//  - Cursor col/row out of range -> no cursor drawn.
//  - Reset mid-line: pipe flushed, outputs 0 until 3 clk after rst_n release with valid timing.
// STRUCTURE
//  - text_mode_defs.vh: TEXT_COLS/ROWS, CELL_W=8, CELL_H=16, PIPE_LAT=3, 16x24-bit CGA palette constants.
//  - Sub-module text_palette: 4-bit index -> 24-bit RGB, combinational, used twice (fg, bg).
//  - Parent holds address gen, 3-stage delay lines, frame counter, cursor compare, output regs.
// TESTING
//  - Addr gen: hcount=639,vcount=479,de=1 -> v_addr=2399, v_en=1; hcount=8,vcount=16 -> v_addr=81.
//  - Latency: char 'A'(0x41) attr 0x1F at cell 0, font model -> rgb at clk+3 = white fg / blue bg pattern; syncs lag 3.
//  - Double scan: vcount=2 and 3 -> font_row=1 both; vcount=15 -> font_row=7.
//  - Cursor: en=1,col=5,row=2, frame_ctr bit4=1 -> lines 46,47 x=40..47 fg; frame bit4=0 -> normal glyph.
//  - Blink attr 0x87: 16 frames glyph visible, 16 frames solid bg; frame ctr wrap 255->0 toggles correctly.
//  - Reset asserted mid-line: all outputs 0 immediately (async), de_out stays 0 for 3 clk after release.

Source files
------------

// File: rtl/text_pixel_pipe_pkg.sv
// Shared constants and types for the 80x30 text-mode render pipeline.
// Holds the cell geometry, the pipe latency and the 16-entry CGA palette.
package text_pixel_pipe_pkg;

  localparam int unsigned TEXT_COLS = 80;
  localparam int unsigned TEXT_ROWS = 30;
  localparam int unsigned CELL_W    = 8;
  localparam int unsigned CELL_H    = 16;
  localparam int unsigned PIPE_LAT  = 3;

  typedef logic [23:0] rgb_t;

  localparam rgb_t CGA_PALETTE [0:15] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };

  // Per-pixel side information carried alongside the RAM/ROM lookups.
  typedef struct packed {
    logic       de;
    logic       hsync;
    logic       vsync;
    logic       cell_ok;
    logic       cursor;
    logic       blink;
    logic [2:0] px;
  } pix_stage_t;

endpackage

// File: rtl/text_pixel_pipe_if.sv
// Video-side port bundle: char/attr RAM read port plus font ROM lookup.
// master = render pipe, slave = memories.
interface text_pixel_pipe_if;

  logic        v_en;
  logic [11:0] v_addr;
  logic [7:0]  v_char;
  logic [7:0]  v_attr;
  logic [7:0]  font_char;
  logic [2:0]  font_row;
  logic [7:0]  font_pixels;

  modport master (
    output v_en, v_addr, font_char, font_row,
    input  v_char, v_attr, font_pixels
  );

  modport slave (
    input  v_en, v_addr, font_char, font_row,
    output v_char, v_attr, font_pixels
  );

endinterface

// File: rtl/text_pixel_pipe_palette.sv
// 4-bit colour index to 24-bit RGB lookup, purely combinational.
module text_palette
  import text_pixel_pipe_pkg::*;
(
  input  logic [3:0] idx,
  output rgb_t       rgb
);

  assign rgb = CGA_PALETTE[idx];

endmodule

// File: rtl/text_pixel_pipe.sv
// Text-mode pixel pipeline: cell address generation, glyph/attribute lookup,
// cursor and blink overlay, with syncs delayed to match the 3-clock RGB latency.
module text_pixel_pipe
  import text_pixel_pipe_pkg::*;
#(
  parameter int unsigned COLS      = TEXT_COLS,
  parameter int unsigned ROWS      = TEXT_ROWS,
  parameter int unsigned BLINK_BIT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [9:0]               hcount,
  input  logic [9:0]               vcount,
  input  logic                     de_in,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic                     cursor_en,
  input  logic [6:0]               cursor_col,
  input  logic [4:0]               cursor_row,
  text_pixel_pipe_if.master        mem,
  output rgb_t                     rgb,
  output logic                     de_out,
  output logic                     hsync_out,
  output logic                     vsync_out
);

  localparam logic [6:0] COLS_W = 7'(COLS);
  localparam logic [5:0] ROWS_W = 6'(ROWS);

  logic [6:0]  col;
  logic [5:0]  row;
  logic        cell_ok;
  logic [11:0] cell_addr;
  pix_stage_t  s0, s1, s2;
  logic [2:0]  row_d1;
  logic [7:0]  attr_d2;
  logic        vsync_q;
  logic [7:0]  frame_ctr;
  logic [3:0]  fg_idx, bg_idx;
  rgb_t        fg_rgb, bg_rgb, pix_rgb;
  logic        glyph_bit;

  // Stage 0: cell lookup. An out-of-range cursor never matches because cell_ok masks the cell.
  always_comb begin
    col       = hcount[9:3];
    row       = vcount[9:4];
    cell_ok   = de_in && (col < COLS_W) && (row < ROWS_W);
    cell_addr = 12'(row) * 12'(COLS) + 12'(col);
    s0         = '0;
    s0.de      = de_in;
    s0.hsync   = hsync_in;
    s0.vsync   = vsync_in;
    s0.cell_ok = cell_ok;
    s0.cursor  = cursor_en && (col == cursor_col) && (row == {1'b0, cursor_row})
                 && (vcount[3:0] >= 4'(CELL_H - 2));
    s0.blink   = frame_ctr[BLINK_BIT];
    s0.px      = hcount[2:0];
  end

  // The combinational memory-side outputs are held at 0 during reset, like the registers.
  assign mem.v_en      = rst_n && cell_ok;
  assign mem.v_addr    = rst_n ? cell_addr : '0;
  assign mem.font_char = rst_n ? mem.v_char : '0;
  assign mem.font_row  = row_d1;

  text_palette u_fg_pal (.idx(fg_idx), .rgb(fg_rgb));
  text_palette u_bg_pal (.idx(bg_idx), .rgb(bg_rgb));

  // Stage 2: glyph bit and colour select; blinking chars show fg as bg in the low phase.
  always_comb begin
    bg_idx    = {1'b0, attr_d2[6:4]};
    fg_idx    = (attr_d2[7] && !s2.blink) ? bg_idx : attr_d2[3:0];
    glyph_bit = mem.font_pixels[3'd7 - s2.px];
    pix_rgb   = '0;
    if (s2.de && s2.cell_ok) begin
      if ((s2.cursor && s2.blink) || glyph_bit)
        pix_rgb = fg_rgb;
      else
        pix_rgb = bg_rgb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= '0;
      s2        <= '0;
      row_d1    <= '0;
      attr_d2   <= '0;
      vsync_q   <= 1'b0;
      frame_ctr <= '0;
      rgb       <= '0;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      s1        <= s0;
      s2        <= s1;
      row_d1    <= vcount[3:1];
      attr_d2   <= mem.v_attr;
      vsync_q   <= vsync_in;
      if (vsync_in && !vsync_q)
        frame_ctr <= frame_ctr + 8'd1;
      rgb       <= pix_rgb;
      de_out    <= s2.de;
      hsync_out <= s2.hsync;
      vsync_out <= s2.vsync;
    end
  end

endmodule

// File: tb/tb_text_pixel_pipe.sv
// Self-checking bench for text_pixel_pipe: memory models, a cell/glyph-level
// reference model, address/double-scan tables, cursor/blink/reset sequences, random pixels.
module tb_text_pixel_pipe;
  import text_pixel_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  hcount, vcount;
  logic        de_in, hsync_in, vsync_in;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [23:0] rgb;
  logic        de_out, hsync_out, vsync_out;

  text_pixel_pipe_if mem_if ();

  text_pixel_pipe #(.COLS(80), .ROWS(30), .BLINK_BIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .hcount(hcount), .vcount(vcount),
    .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .mem(mem_if),
    .rgb(rgb), .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  logic [7:0] char_mem [0:4095];
  logic [7:0] attr_mem [0:4095];

  function automatic logic [7:0] font_bits(input logic [7:0] ch, input logic [2:0] r);
    int unsigned v;
    v = int'(ch) * 29 + int'(r) * 71 + (int'(ch) >> 2) * int'(r);
    return 8'(v ^ (v >> 3));
  endfunction

  // Synchronous RAM and font ROM, one clock read latency each.
  always @(posedge clk) begin
    if (mem_if.v_en) begin
      mem_if.v_char <= char_mem[mem_if.v_addr];
      mem_if.v_attr <= attr_mem[mem_if.v_addr];
    end
    mem_if.font_pixels <= font_bits(mem_if.font_char, mem_if.font_row);
  end

  function automatic logic [23:0] cga(input int i);
    logic [7:0] hi, r, g, b;
    hi = (i >= 8) ? 8'h55 : 8'h00;
    r  = (((i & 4) != 0) ? 8'hAA : 8'h00) + hi;
    g  = (((i & 2) != 0) ? 8'hAA : 8'h00) + hi;
    b  = (((i & 1) != 0) ? 8'hAA : 8'h00) + hi;
    if (i == 6) g = 8'h55;
    return {r, g, b};
  endfunction

  function automatic logic [23:0] ref_pixel(input int h, input int v, input bit de,
                                            input bit cen, input int ccol, input int crow,
                                            input int frames);
    int col, row, idx, fg, bg;
    logic [7:0] ch, at, bits;
    bit blink, on;
    col = h / 8;
    row = v / 16;
    if (!de || col >= 80 || row >= 30) return 24'h0;
    idx   = row * 80 + col;
    ch    = char_mem[idx];
    at    = attr_mem[idx];
    blink = ((frames % 256) / 16) % 2 == 1;
    bg    = int'(at[6:4]);
    fg    = (at[7] && !blink) ? bg : int'(at[3:0]);
    bits  = font_bits(ch, 3'((v % 16) / 2));
    on    = bits[7 - (h % 8)];
    if (cen && ccol == col && crow == row && (v % 16) >= 14 && blink) on = 1'b1;
    return on ? cga(fg) : cga(bg);
  endfunction

  typedef struct { logic [23:0] rgb; logic de; logic hs; logic vs; } exp_t;
  typedef struct { int h; int v; bit de; int addr; bit en; } addr_vec_t;

  exp_t       expq [$];
  int         checks = 0;
  int         errors = 0;
  int         frames;
  bit         vs_prev;
  logic [2:0] last_fr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic reset_model();
    exp_t z;
    z = '{24'h0, 1'b0, 1'b0, 1'b0};
    expq.delete();
    expq.push_back(z);
    expq.push_back(z);
    frames  = 0;
    vs_prev = 1'b0;
    last_fr = 3'd0;
  endtask

  // Starts at a negedge: drive one pixel, check the stage-0 outputs, then at the
  // next negedge compare the pipe output belonging to the pixel driven 2 steps earlier.
  task automatic step(input int h, input int v, input bit de, input bit hs, input bit vs);
    exp_t e, o;
    int   ea;
    bit   een;
    hcount   = 10'(h);
    vcount   = 10'(v);
    de_in    = de;
    hsync_in = hs;
    vsync_in = vs;
    e.rgb = ref_pixel(h, v, de, cursor_en, int'(cursor_col), int'(cursor_row), frames);
    e.de  = de;
    e.hs  = hs;
    e.vs  = vs;
    expq.push_back(e);
    if (vs && !vs_prev) frames++;
    vs_prev = vs;
    last_fr = 3'((v % 16) / 2);
    #1;
    ea  = ((v / 16) * 80 + h / 8) % 4096;
    een = de && (h / 8) < 80 && (v / 16) < 30;
    check("v_addr", 32'(mem_if.v_addr), 32'(ea));
    check("v_en", 32'(mem_if.v_en), 32'(een));
    @(negedge clk);
    o = expq.pop_front();
    check("rgb", 32'(rgb), 32'(o.rgb));
    check("de_out", 32'(de_out), 32'(o.de));
    check("hsync_out", 32'(hsync_out), 32'(o.hs));
    check("vsync_out", 32'(vsync_out), 32'(o.vs));
    check("font_row", 32'(mem_if.font_row), 32'(last_fr));
  endtask

  task automatic frame_pulse();
    step(0, 490, 1'b0, 1'b0, 1'b1);
    step(0, 490, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    addr_vec_t avec [6];
    avec[0] = '{639, 479, 1'b1, 2399, 1'b1};
    avec[1] = '{8,   16,  1'b1, 81,   1'b1};
    avec[2] = '{0,   0,   1'b1, 0,    1'b1};
    avec[3] = '{640, 0,   1'b1, 80,   1'b0};
    avec[4] = '{0,   480, 1'b1, 2400, 1'b0};
    avec[5] = '{100, 100, 1'b0, 492,  1'b0};

    for (int i = 0; i < 4096; i++) begin
      char_mem[i] = 8'(i * 7 + 3);
      attr_mem[i] = 8'(i * 13 + 1) & 8'h7F;
    end
    char_mem[0] = 8'h41;
    attr_mem[0] = 8'h1F;

    // Reset with active inputs: everything must read 0.
    rst_n = 1'b0;
    hcount = 10'd5; vcount = 10'd3; de_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    cursor_en = 1'b0; cursor_col = 7'd0; cursor_row = 5'd0;
    #1;
    check("rst_rgb", 32'(rgb), 32'h0);
    check("rst_de_out", 32'(de_out), 32'h0);
    check("rst_hsync_out", 32'(hsync_out), 32'h0);
    check("rst_vsync_out", 32'(vsync_out), 32'h0);
    check("rst_v_en", 32'(mem_if.v_en), 32'h0);
    check("rst_v_addr", 32'(mem_if.v_addr), 32'h0);
    check("rst_font_row", 32'(mem_if.font_row), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    reset_model();

    for (int i = 0; i < 6; i++) begin
      step(avec[i].h, avec[i].v, avec[i].de, 1'b0, 1'b0);
      check("addr_table", 32'(mem_if.v_addr), 32'(avec[i].addr));
      check("en_table", 32'(mem_if.v_en), 32'(avec[i].en));
    end

    // 'A' with white-on-blue at cell 0, syncs toggled to show their alignment.
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < 10; h++)
        step(h, v, 1'b1, (h % 3) == 0, h == 4);
    for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0, 1'b0);

    step(16, 2, 1'b1, 1'b0, 1'b0);
    check("dscan_v2", 32'(mem_if.font_row), 32'd1);
    step(16, 3, 1'b1, 1'b0, 1'b0);
    check("dscan_v3", 32'(mem_if.font_row), 32'd1);
    step(16, 15, 1'b1, 1'b0, 1'b0);
    check("dscan_v15", 32'(mem_if.font_row), 32'd7);

    // Cursor at (col 5,row 2), in both blink phases.
    char_mem[2 * 80 + 5] = 8'h00;
    attr_mem[2 * 80 + 5] = 8'h2E;
    cursor_en = 1'b1; cursor_col = 7'd5; cursor_row = 5'd2;
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 40 && ((frames / 16) % 2) != 1 - ph; n++) frame_pulse();
      for (int v = 44; v < 48; v++)
        for (int h = 36; h < 52; h++)
          step(h, v, 1'b1, 1'b0, 1'b0);
    end
    cursor_en = 1'b0;

    // Blink attribute across a full frame-counter wrap.
    char_mem[10 * 80 + 40] = 8'h5A;
    attr_mem[10 * 80 + 40] = 8'h87;
    for (int f = 0; f < 300; f++) begin
      frame_pulse();
      for (int h = 320; h < 328; h++)
        step(h, 160 + (f % 16), 1'b1, 1'b0, 1'b0);
    end

    // Random pixels, memory contents and cursor settings.
    for (int i = 0; i < 2400; i++) begin
      char_mem[i] = 8'($urandom);
      attr_mem[i] = 8'($urandom);
    end
    for (int n = 0; n < 2000; n++) begin
      if (n % 50 == 0) begin
        cursor_en  = 1'($urandom);
        cursor_col = 7'($urandom_range(0, 127));
        cursor_row = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 1) == 0) cursor_col = 7'($urandom_range(0, 79));
      end
      step(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    end

    // Reset asserted mid-line with the pipe full of visible pixels.
    for (int h = 0; h < 20; h++) step(h, 100, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rgb", 32'(rgb), 32'h0);
    check("midrst_de_out", 32'(de_out), 32'h0);
    check("midrst_hsync_out", 32'(hsync_out), 32'h0);
    check("midrst_v_en", 32'(mem_if.v_en), 32'h0);
    check("midrst_v_addr", 32'(mem_if.v_addr), 32'h0);
    check("midrst_font_char", 32'(mem_if.font_char), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    for (int h = 20; h < 40; h++) step(h, 100, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
